sgf_mult_norm_round: RTL
========================

Name: sgf_mult_norm_round

Overview:
- Stage directly downstream of Sgf_Multiplication.
- Consumes the 2*SW-bit significand product and normalises it to SW bits, hidden bit included.
- Rounds with guard/sticky and reports the exponent adjustment plus inexact/zero flags to the exponent/pack logic.
- Two-stage valid/ready pipeline.

Parameters:
- SW, 24, significand width including hidden bit (24 single, 53 double); product width is 2*SW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  product_i holds a new product.
- ready_o  out  1  block can accept this cycle.
- product_i  in  2*SW  unsigned product of two normalised significands, or 0.
- valid_o  out  1  result outputs valid.
- ready_i  in  1  consumer accepts the result.
- sgf_o  out  SW  normalised, rounded significand; MSB is the hidden bit.
- exp_inc_o  out  1  1 = add 1 to the biased exponent sum.
- inexact_o  out  1  guard|sticky was nonzero.
- zero_o  out  1  product_i was zero.

Behaviour:
- Reset, asynchronous and immediate: all pipeline registers and outputs are 0 (valid_o=0, sgf_o=0, exp_inc_o=0, inexact_o=0, zero_o=0). ready_o=1 after reset.
- Transfer occurs on valid_i & ready_o. Result is taken on valid_o & ready_i.
- Latency: 2 cycles from accepted input to valid_o when unstalled; throughput 1/cycle.
- Stall: adv = ~valid_o | ready_i; ready_o = adv, combinational. When adv=0 both stages hold and outputs stay stable.
- Bubbles: an empty stage propagates valid=0; data registers may hold stale values.
- Stage 1, normalise (P=product_i):
  - If P[2SW-1]=1: m=P[2SW-1:SW], g=P[SW-1], s=|P[SW-2:0], e=1.
  - Else: m=P[2SW-2:SW-1], g=P[SW-2], s=|P[SW-3:0], e=0.
  - z=(P==0). Register m, g, s, e, z, v1.
- Stage 2, round to nearest even: up = g & (s | m[0]); r = m + up, computed SW+1 bits wide.
  - If r[SW]=1 (round carry): sgf_o=1 followed by SW-1 zeros, exp_inc_o=1.
  - Otherwise: sgf_o=r[SW-1:0], exp_inc_o=e.
  - inexact_o = g|s.
- Carry can only occur when e=0 (max product bounds m+up in the shifted case), so exp_inc_o never needs 2.
- Zero product: sgf_o=0, exp_inc_o=0, inexact_o=0, zero_o=1.
- Reset mid-operation: in-flight items are dropped, no partial outputs appear, and the block resumes accepting on the first cycle after rst falls.
- Simultaneous accept and output with stage 2 full and ready_i=1: both advance the same cycle, with no bubble inserted.

Optional Feature:
- Macro SGF_RNE_ROUND_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncation, with up=0; sgf_o=m, exp_inc_o=e. inexact_o is still computed as g|s.
- Ports are identical in both builds.

Decomposition:
- Shared package fpu_sgf_pkg holds:
  - localparam PW = 2*SW.
  - Typedef struct norm_t {m, g, s, e, z} for the stage-1 to stage-2 register.
  - Rounding-mode constants, for future modes.
- One sub-module, sgf_rne_rounder: combinational round of m/g/s/e to sgf/exp_inc/inexact. Instantiated in stage 2 and reusable by the adder path.

Test Plan (SW=4, SGF_RNE_ROUND_EN defined unless noted):
- 64 (8*8) -> sgf_o=1000, exp_inc_o=0, inexact_o=0 at the 2nd cycle after accept.
- 225 (15*15) -> sgf_o=1110, exp_inc_o=1, inexact_o=1.
- Ties:
  - 108 (9*12), tie with odd LSB -> sgf_o=1110, exp_inc_o=0, inexact_o=1.
  - 168 (12*14), tie with even LSB -> sgf_o=1010, exp_inc_o=1, inexact_o=1.
- Round carry: 126 (9*14) -> sgf_o=1000, exp_inc_o=1, inexact_o=1. With the macro undefined -> sgf_o=1111, exp_inc_o=0.
- Zero and backpressure:
  - product 0 -> zero_o=1, sgf_o=0.
  - Stream 64, 225, 108 back-to-back with ready_i=0 for 3 cycles mid-stream: ready_o=0 while stalled, outputs held, all three delivered in order with none lost or duplicated.
- Reset mid-operation: rst=1 for one cycle with both stages full -> valid_o=0 immediately; next accepted product 64 emerges 2 cycles later as sgf_o=1000.

Source files
------------

// File: rtl/fpu_sgf_pkg.sv
// Shared significand-path types and constants for the FPU multiply/add datapaths.
// norm_t and PW are sized for the default single-precision significand width.
package fpu_sgf_pkg;

  localparam int SGF_SW = 24;
  localparam int PW     = 2 * SGF_SW;

  typedef struct packed {
    logic [SGF_SW-1:0] m;
    logic              g;
    logic              s;
    logic              e;
    logic              z;
  } norm_t;

  // Only nearest-even and truncation are implemented today; the rest are reserved.
  typedef enum logic [1:0] {
    RND_NEAREST_EVEN = 2'd0,
    RND_TRUNC        = 2'd1,
    RND_UP           = 2'd2,
    RND_DOWN         = 2'd3
  } rnd_mode_e;

endpackage

// File: rtl/sgf_rne_rounder.sv
// Combinational significand rounder: m/g/s/e -> sgf/exp_inc/inexact.
// Shared between the multiplier normaliser and the adder path.
module sgf_rne_rounder
  import fpu_sgf_pkg::*;
#(
  parameter int        SW   = 24,
  parameter rnd_mode_e MODE = RND_NEAREST_EVEN
) (
  input  logic [SW-1:0] m_i,
  input  logic          g_i,
  input  logic          s_i,
  input  logic          e_i,
  output logic [SW-1:0] sgf_o,
  output logic          exp_inc_o,
  output logic          inexact_o
);

  logic          w_up;
  logic [SW:0]   w_r;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_up      = (MODE == RND_NEAREST_EVEN) ? (g_i & (s_i | m_i[0])) : 1'b0;
    w_r       = {1'b0, m_i} + (SW+1)'(w_up);
    inexact_o = g_i | s_i;
    if (w_r[SW]) begin
      // All-ones mantissa rounded up: renormalise to 1.000... and bump the exponent.
      sgf_o     = {1'b1, {(SW-1){1'b0}}};
      exp_inc_o = 1'b1;
    end else begin
      sgf_o     = w_r[SW-1:0];
      exp_inc_o = e_i;
    end
  end

endmodule

// File: rtl/sgf_mult_norm_round.sv
// Two-stage valid/ready normalise-and-round of the 2*SW-bit significand product.
// Define SGF_RNE_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module sgf_mult_norm_round
  import fpu_sgf_pkg::*;
#(
  parameter int SW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2*SW-1:0] product_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [SW-1:0]   sgf_o,
  output logic            exp_inc_o,
  output logic            inexact_o,
  output logic            zero_o
);

  localparam int PW_L = 2 * SW;

`ifdef SGF_RNE_ROUND_EN
  localparam rnd_mode_e RND_MODE = RND_NEAREST_EVEN;
`else
  localparam rnd_mode_e RND_MODE = RND_TRUNC;
`endif

  typedef struct packed {
    logic [SW-1:0] m;
    logic          g;
    logic          s;
    logic          e;
    logic          z;
  } stage1_t;

  logic          w_adv;
  logic [SW-1:0] w_m;
  logic          w_g;
  logic          w_s;
  logic          w_e;
  logic          w_z;
  logic [SW-1:0] w_sgf;
  logic          w_exp_inc;
  logic          w_inexact;

  logic          r_v1;
  stage1_t       r_n1;
  logic          r_valid_o;
  logic [SW-1:0] r_sgf;
  logic          r_exp_inc;
  logic          r_inexact;
  logic          r_zero;

  // Both stages move together; the pipe only stalls when a held result is refused.
  assign w_adv   = ~r_valid_o | ready_i;
  assign ready_o = w_adv;

  always_comb begin
    w_e = product_i[PW_L-1];
    w_z = (product_i == '0);
    if (w_e) begin
      w_m = product_i[PW_L-1:SW];
      w_g = product_i[SW-1];
      w_s = |product_i[SW-2:0];
    end else begin
      w_m = product_i[PW_L-2:SW-1];
      w_g = product_i[SW-2];
      w_s = |product_i[SW-3:0];
    end
  end

  sgf_rne_rounder #(
    .SW   (SW),
    .MODE (RND_MODE)
  ) u_rounder (
    .m_i       (r_n1.m),
    .g_i       (r_n1.g),
    .s_i       (r_n1.s),
    .e_i       (r_n1.e),
    .sgf_o     (w_sgf),
    .exp_inc_o (w_exp_inc),
    .inexact_o (w_inexact)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are cleared as well, so outputs read all-zero straight out of reset.
      r_v1      <= 1'b0;
      r_n1      <= '0;
      r_valid_o <= 1'b0;
      r_sgf     <= '0;
      r_exp_inc <= 1'b0;
      r_inexact <= 1'b0;
      r_zero    <= 1'b0;
    end else if (w_adv) begin
      r_v1      <= valid_i;
      r_valid_o <= r_v1;
      if (valid_i) begin
        r_n1 <= '{m: w_m, g: w_g, s: w_s, e: w_e, z: w_z};
      end
      if (r_v1) begin
        r_sgf     <= w_sgf;
        r_exp_inc <= w_exp_inc;
        r_inexact <= w_inexact;
        r_zero    <= r_n1.z;
      end
    end
  end

  assign valid_o   = r_valid_o;
  assign sgf_o     = r_sgf;
  assign exp_inc_o = r_exp_inc;
  assign inexact_o = r_inexact;
  assign zero_o    = r_zero;

endmodule
